// File: rtl/hms_time_counter.sv
// hms_time_counter: time-of-day counter for the seg7 clock.
// Divides the board clock down to a one-second strobe and keeps hh:mm:ss.
// A key-driven set mode walks through the fields (RUN -> SET_HH -> SET_MM ->
// SET_SS -> RUN). It publishes the packed value hh*10000 + mm*100 + ss for
// the downstream binary-to-BCD converter.
// Optional feature macro: HMS_12H_EN selects 12-hour mode with a pm output.
// When the macro is undefined, the counter runs in 24-hour mode.

module hms_time_counter #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [23:0] time_bin,
  output logic [2:0]  sel,
  output logic        tick_1hz,
  output logic        day_carry
`ifdef HMS_12H_EN
  ,
  output logic        pm
`endif
);

  // Prescaler is just wide enough to hold CLK_FREQ-1.
  localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

`ifdef HMS_12H_EN
  localparam logic [4:0] HH_RESET = 5'd12;
`else
  localparam logic [4:0] HH_RESET = 5'd0;
`endif

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_next;
  logic            sec_step;
  logic            inc_fire;

  logic [4:0]      hh;
  logic [5:0]      mm;
  logic [5:0]      ss;
  logic [4:0]      hh_next;
  logic [5:0]      mm_next;
  logic [5:0]      ss_next;

  logic [4:0]      hh_inc;
  logic [5:0]      mm_inc;
  logic [5:0]      ss_inc;
  logic            hh_rolls_day;
  logic            tick_next;
  logic            carry_next;

`ifdef HMS_12H_EN
  logic            pm_flip;
  logic            pm_next;
`endif

  // State register for the set-mode walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // key_mode advances the mode; it is the only thing that changes state.
  always_comb begin
    state_next = state;
    if (key_mode) begin
      case (state)
        RUN:     state_next = SET_HH;
        SET_HH:  state_next = SET_MM;
        SET_MM:  state_next = SET_SS;
        SET_SS:  state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // One-hot field select decoded from the current state.
  always_comb begin
    sel = 3'b000;
    case (state)
      SET_HH:  sel = 3'b100;
      SET_MM:  sel = 3'b010;
      SET_SS:  sel = 3'b001;
      default: sel = 3'b000;
    endcase
  end

  // Prescaler counts in RUN only; it is parked at zero while setting.
  always_comb begin
    presc_next = '0;
    sec_step   = 1'b0;
    if (state == RUN) begin
      if (presc == PRESC_LAST) begin
        sec_step = 1'b1;
      end else begin
        presc_next = presc + PW'(1);
      end
    end
  end

  // An increment only counts in a set state and loses to a simultaneous mode key.
  always_comb begin
    inc_fire = (state != RUN) && key_inc && !key_mode;
  end

  // Wrapped successors of each field, shared by the running clock and the set keys.
  always_comb begin
    ss_inc = (ss == 6'd59) ? 6'd0 : ss + 6'd1;
    mm_inc = (mm == 6'd59) ? 6'd0 : mm + 6'd1;
`ifdef HMS_12H_EN
    hh_inc       = (hh == 5'd12) ? 5'd1 : hh + 5'd1;
    pm_flip      = (hh == 5'd11);
    hh_rolls_day = (hh == 5'd11) && pm;
`else
    hh_inc       = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
    hh_rolls_day = (hh == 5'd23);
`endif
  end

  // Next field values: a second step ripples carries, a set increment stays in its field.
  always_comb begin
    ss_next    = ss;
    mm_next    = mm;
    hh_next    = hh;
    tick_next  = 1'b0;
    carry_next = 1'b0;
`ifdef HMS_12H_EN
    pm_next    = pm;
`endif
    if (sec_step) begin
      tick_next = 1'b1;
      ss_next   = ss_inc;
      if (ss == 6'd59) begin
        mm_next = mm_inc;
        if (mm == 6'd59) begin
          hh_next    = hh_inc;
          carry_next = hh_rolls_day;
`ifdef HMS_12H_EN
          if (pm_flip) begin
            pm_next = !pm;
          end
`endif
        end
      end
    end else if (inc_fire) begin
      case (state)
        SET_HH: begin
          hh_next = hh_inc;
`ifdef HMS_12H_EN
          if (pm_flip) begin
            pm_next = !pm;
          end
`endif
        end
        SET_MM:  mm_next = mm_inc;
        SET_SS:  ss_next = ss_inc;
        default: ;
      endcase
    end
  end

  // Prescaler, time fields and the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      hh        <= HH_RESET;
      mm        <= 6'd0;
      ss        <= 6'd0;
      tick_1hz  <= 1'b0;
      day_carry <= 1'b0;
    end else begin
      presc     <= presc_next;
      hh        <= hh_next;
      mm        <= mm_next;
      ss        <= ss_next;
      tick_1hz  <= tick_next;
      day_carry <= carry_next;
    end
  end

`ifdef HMS_12H_EN
  // AM/PM flag, toggled on the 11 -> 12 hour step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pm <= 1'b0;
    end else begin
      pm <= pm_next;
    end
  end
`endif

  // Packed display value from the registered fields, one cycle behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_bin <= {19'd0, HH_RESET} * 24'd10000;
    end else begin
      time_bin <= ({19'd0, hh} * 24'd10000)
                + ({18'd0, mm} * 24'd100)
                + {18'd0, ss};
    end
  end

endmodule
